// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, time-shared by serial_add_ctrl.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  assign Y    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell walks LSB to MSB over WIDTH cycles,
// with a start/busy/done handshake around it.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_y;
  logic             fa_cout;

  full_adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Y    (fa_y),
    .Cout (fa_cout)
  );

  // Each new bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign res_next = {fa_y, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_ADD;
      S_ADD:   if (cnt == LAST) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_ADD:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        S_ADD: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          // Results are published only once the MSB has been added.
          if (cnt == LAST) begin
            sum  <= res_next;
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=2 against a plain a+b model.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start8, start2;
  logic [7:0] a8, b8, sum8;
  logic [1:0] a2, b2, sum2;
  logic       busy8, done8, cout8;
  logic       busy2, done2, cout2;

  int vectors;
  int miscompares;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start pulse on dut8 and observes `span` following cycles.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit scramble,
                     input bit poke, input int span, output int nbusy, output int ndone,
                     output int lat, output logic [7:0] s, output logic c, output bit moved);
    logic [7:0] s0;
    logic       c0;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    s0 = sum8; c0 = cout8;
    nbusy = 0; ndone = 0; lat = -1; s = 'x; c = 1'bx; moved = 1'b0;
    for (int i = 1; i <= span; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
      if (busy8) begin
        nbusy++;
        if (sum8 !== s0 || cout8 !== c0) moved = 1'b1;
        if (scramble) begin a8 = 8'($urandom); b8 = 8'($urandom); end
        if (poke && nbusy == 3) begin
          start8 = 1'b1; a8 = ~av; b8 = ~bv;
        end else if (poke && nbusy == 4) begin
          start8 = 1'b0;
        end
      end
      if (done8) begin
        ndone++;
        if (lat < 0) begin lat = i; s = sum8; c = cout8; end
      end
    end
    start8 = 1'b0;
  endtask

  task automatic op2(input logic [1:0] av, input logic [1:0] bv, output int nbusy,
                     output int ndone, output int lat, output logic [1:0] s, output logic c);
    @(negedge clk);
    a2 = av; b2 = bv; start2 = 1'b1;
    nbusy = 0; ndone = 0; lat = -1; s = 'x; c = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) start2 = 1'b0;
      if (busy2) nbusy++;
      if (done2) begin
        ndone++;
        if (lat < 0) begin lat = i; s = sum2; c = cout2; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset8: busy/done/sum/cout=%b, expected all zero", {busy8, done8, sum8, cout8});
    end
    vectors++;
    if ({busy2, done2, sum2, cout2} !== 5'd0) begin
      miscompares++;
      $display("FAIL reset2: busy/done/sum/cout=%b, expected all zero", {busy2, done2, sum2, cout2});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Checks result, latency, busy length and single done pulse for one operation.
  task automatic test_add8(input string name, input logic [7:0] av, input logic [7:0] bv,
                           input bit scramble, input bit poke);
    int nb, nd, lat;
    logic [7:0] s;
    logic c, moved;
    logic [8:0] exp;
    exp = {1'b0, av} + {1'b0, bv};
    op8(av, bv, scramble, poke, 24, nb, nd, lat, s, c, moved);
    vectors++;
    if ({c, s} !== exp) begin
      miscompares++;
      $display("FAIL %s result: a=%h b=%h got cout=%b sum=%h, expected cout=%b sum=%h",
               name, av, bv, c, s, exp[8], exp[7:0]);
    end
    vectors++;
    if (nb !== 8 || nd !== 1 || lat !== 9) begin
      miscompares++;
      $display("FAIL %s timing: busy=%0d done=%0d latency=%0d, expected 8/1/9", name, nb, nd, lat);
    end
    vectors++;
    if (moved !== 1'b0) begin
      miscompares++;
      $display("FAIL %s hold: sum/cout changed during ADD (moved=%b), expected stable", name, moved);
    end
  endtask

  task automatic test_basic();
    test_add8("basic", 8'h5A, 8'h3C, 1'b0, 1'b0);
    test_add8("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    test_add8("wrap_ff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++)
      test_add8("random", 8'($urandom), 8'($urandom), k[0], 1'b0);
  endtask

  task automatic test_robust();
    test_add8("scramble", 8'h10, 8'h20, 1'b1, 1'b0);
    test_add8("start_busy", 8'h21, 8'h43, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int d_idx[$];
    logic [7:0] d_sum[$];
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin d_idx.push_back(i); d_sum.push_back(sum8); end
    end
    start8 = 1'b0;
    vectors++;
    if (d_idx.size() < 3) begin
      miscompares++;
      $display("FAIL b2b count: %0d done pulses in 40 cycles, expected at least 3", d_idx.size());
    end else begin
      vectors++;
      if (d_idx[0] !== 9 || d_idx[1] - d_idx[0] !== 10 || d_idx[2] - d_idx[1] !== 10) begin
        miscompares++;
        $display("FAIL b2b spacing: done at %0d,%0d,%0d, expected 9,19,29", d_idx[0], d_idx[1], d_idx[2]);
      end
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (d_sum[j] !== 8'h30 || cout8 !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b sum[%0d]: got %h cout=%b, expected 30 cout=0", j, d_sum[j], cout8);
        end
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nb, nd, lat;
    logic [7:0] s;
    logic c, moved;
    bit saw_done;
    int guard;
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h5A; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nb = 0; guard = 0;
    while (nb < 4 && guard < 20) begin
      if (busy8) nb++;
      if (nb < 4) @(negedge clk);
      guard++;
    end
    vectors++;
    if (nb !== 4) begin
      miscompares++;
      $display("FAIL rst_mid reach: busy cycles seen=%0d, expected 4", nb);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      miscompares++;
      $display("FAIL rst_mid async: busy/done/sum/cout=%b, expected all zero", {busy8, done8, sum8, cout8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid abort: activity after reset=%b, expected none", saw_done);
    end
    op8(8'h01, 8'h02, 1'b0, 1'b0, 14, nb, nd, lat, s, c, moved);
    vectors++;
    if ({c, s} !== 9'h003 || nd !== 1) begin
      miscompares++;
      $display("FAIL rst_mid recover: cout=%b sum=%h done=%0d, expected 0/03/1", c, s, nd);
    end
  endtask

  task automatic test_width2();
    int nb, nd, lat;
    logic [1:0] s;
    logic c;
    logic [2:0] exp;
    op2(2'b11, 2'b11, nb, nd, lat, s, c);
    vectors++;
    if ({c, s} !== 3'b110 || nb !== 2 || lat !== 3) begin
      miscompares++;
      $display("FAIL w2 11+11: cout=%b sum=%b busy=%0d lat=%0d, expected 1/10/2/3", c, s, nb, lat);
    end
    for (int i = 0; i < 16; i++) begin
      exp = {1'b0, 2'(i >> 2)} + {1'b0, 2'(i)};
      op2(2'(i >> 2), 2'(i), nb, nd, lat, s, c);
      vectors++;
      if ({c, s} !== exp || nd !== 1 || nb !== 2) begin
        miscompares++;
        $display("FAIL w2 sweep a=%0d b=%0d: cout=%b sum=%b done=%0d busy=%0d, expected %b/1/2",
                 i >> 2, i & 3, c, s, nd, nb, exp);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    test_reset();
    test_basic();
    test_robust();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_width2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
